// File: rtl/line_transmitter_if.sv
// Character-source / UART-line bundle for line_transmitter.
// master = character source side, slave = the transmitter.
interface line_transmitter_if #(
   parameter int unsigned DEPTH = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             char_valid;
   logic [7:0]       char_data;
   logic             send;
   logic             clear;
   logic             tx;
   logic             busy;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             overflow;
   logic             byte_done;

   modport master (
      output char_valid, char_data, send, clear,
      input  tx, busy, count, full, overflow, byte_done
   );

   modport slave (
      input  char_valid, char_data, send, clear,
      output tx, busy, count, full, overflow, byte_done
   );
endinterface

// File: rtl/line_transmitter.sv
// Line-buffered UART 8N1 transmitter: collects characters, then sends the
// whole line LSB first followed by the NEWLINE terminator byte.
module line_transmitter #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DEPTH    = 32,
   parameter logic [7:0]  NEWLINE  = 8'h7E
) (
   input  logic               clk,
   input  logic               reset,
   line_transmitter_if.slave  bus
);
   localparam int unsigned CPB    = CLK_FREQ / BAUD;
   localparam int unsigned BAUD_W = $clog2(CPB);
   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned CNT_W  = AW + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  rd;
   logic              is_term;
   logic              tx;
   logic              busy;
   logic              full;
   logic              overflow;
   logic              byte_done;

   logic              append_c;
   logic [CNT_W-1:0]  cnt_nxt_c;
   logic [CNT_W-1:0]  rd_nxt_c;
   logic [7:0]        first_c;

   // Idle-side line edits: clear beats append; an append in the send cycle joins the line
   always_comb begin
      append_c  = bus.char_valid && !bus.clear && (count < DEPTH_C);
      cnt_nxt_c = count;
      if (bus.clear)
         cnt_nxt_c = '0;
      else if (append_c)
         cnt_nxt_c = count + CNT_W'(1);
      first_c  = (count == '0) ? bus.char_data : mem[0];
      rd_nxt_c = rd + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset && state == IDLE && append_c)
         mem[count[AW-1:0]] <= bus.char_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         count     <= '0;
         rd        <= '0;
         is_term   <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         full      <= 1'b0;
         overflow  <= 1'b0;
         byte_done <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         overflow  <= (state != IDLE) && bus.char_valid;
         case (state)
            IDLE: begin
               count    <= cnt_nxt_c;
               full     <= (cnt_nxt_c == DEPTH_C);
               overflow <= bus.char_valid && !bus.clear && !append_c;
               if (bus.send) begin
                  state    <= START;
                  busy     <= 1'b1;
                  tx       <= 1'b0;
                  baud_cnt <= '0;
                  rd       <= '0;
                  is_term  <= (cnt_nxt_c == '0);
                  shift    <= (cnt_nxt_c == '0) ? NEWLINE : first_c;
               end
            end
            START: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  tx       <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            STOP: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt  <= '0;
                  state     <= NEXT;
                  byte_done <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            NEXT: begin
               // is_term, not the byte value, marks the end so 0x7E data is safe
               if (is_term) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  count   <= '0;
                  full    <= 1'b0;
                  rd      <= '0;
                  is_term <= 1'b0;
               end else begin
                  state <= START;
                  tx    <= 1'b0;
                  if (rd_nxt_c < count) begin
                     rd    <= rd_nxt_c;
                     shift <= mem[rd_nxt_c[AW-1:0]];
                  end else begin
                     shift   <= NEWLINE;
                     is_term <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx        = tx;
   assign bus.busy      = busy;
   assign bus.count     = count;
   assign bus.full      = full;
   assign bus.overflow  = overflow;
   assign bus.byte_done = byte_done;
endmodule

// File: tb/tb_line_transmitter.sv
// Randomized bench for line_transmitter: a queue model of the line buffer
// and a cycle-position UART decoder derived from the frame timing.
module tb_line_transmitter;
   localparam int unsigned CLK_FREQ = 16;
   localparam int unsigned BAUD     = 1;
   localparam int unsigned CPB      = CLK_FREQ / BAUD;
   localparam int unsigned DEPTH    = 32;
   localparam int unsigned BYTE_T   = 10 * CPB + 1;
   localparam logic [7:0]  NL       = 8'h7E;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic [7:0] line_q[$];

   line_transmitter_if #(.DEPTH(DEPTH)) bus ();

   line_transmitter #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD),
      .DEPTH   (DEPTH),
      .NEWLINE (NL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic append(input logic [7:0] ch);
      bit exp_ovf;
      exp_ovf = (line_q.size() >= DEPTH);
      bus.char_valid = 1'b1;
      bus.char_data  = ch;
      @(negedge clk);
      bus.char_valid = 1'b0;
      if (!exp_ovf) line_q.push_back(ch);
      check("append_overflow", 32'(bus.overflow), 32'(exp_ovf));
      check("append_count", 32'(bus.count), 32'(line_q.size()));
      check("append_full", 32'(bus.full), 32'(line_q.size() == DEPTH));
   endtask

   // Send the line and decode every frame at fixed cycle positions after the accepting edge
   task automatic run_send(input bit with_char, input logic [7:0] ch,
                           input bit with_clear, input bit inject);
      logic [7:0] exp_q[$];
      logic [7:0] sh;
      int total, busy_cycles, done_cnt, b, p;
      if (with_clear) line_q.delete();
      else if (with_char && line_q.size() < DEPTH) line_q.push_back(ch);
      exp_q = line_q;
      exp_q.push_back(NL);
      total = exp_q.size() * BYTE_T;
      busy_cycles = 0;
      done_cnt = 0;
      sh = '0;
      bus.send       = 1'b1;
      bus.char_valid = with_char;
      bus.char_data  = ch;
      bus.clear      = with_clear;
      @(negedge clk);
      bus.send       = 1'b0;
      bus.char_valid = 1'b0;
      bus.clear      = 1'b0;
      check("send_busy_rise", 32'(bus.busy), 32'd1);
      check("send_first_start", 32'(bus.tx), 32'd0);
      for (int k = 0; k <= total; k++) begin
         b = k / BYTE_T;
         p = k % BYTE_T;
         if (k < total) begin
            if (bus.busy) busy_cycles++;
            if (bus.byte_done) done_cnt++;
            if (p == CPB / 2) check("start_bit", 32'(bus.tx), 32'd0);
            if (p >= 24 && p <= 136 && (p % 16) == 8) sh = {bus.tx, sh[7:1]};
            if (p == 152) begin
               check("stop_bit", 32'(bus.tx), 32'd1);
               check($sformatf("frame_byte%0d", b), 32'(sh), 32'(exp_q[b]));
            end
            if (inject && k == 51) begin
               bus.char_valid = 1'b0;
               bus.send       = 1'b0;
               bus.clear      = 1'b0;
               check("busy_overflow", 32'(bus.overflow), 32'd1);
            end
            if (inject && k == 50) begin
               bus.char_valid = 1'b1;
               bus.char_data  = 8'h55;
               bus.send       = 1'b1;
               bus.clear      = 1'b1;
            end
            @(negedge clk);
         end else begin
            check("busy_fall", 32'(bus.busy), 32'd0);
            check("count_after_line", 32'(bus.count), 32'd0);
         end
      end
      check("busy_length", 32'(busy_cycles), 32'(total));
      check("byte_done_pulses", 32'(done_cnt), 32'(exp_q.size()));
      line_q.delete();
   endtask

   initial begin
      int len, tx_low, busy_hi;
      logic [7:0] ch;
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1;
      bus.char_valid = 1'b0;
      bus.char_data  = '0;
      bus.send       = 1'b0;
      bus.clear      = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      check("reset_tx", 32'(bus.tx), 32'd1);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_count", 32'(bus.count), 32'd0);
      check("reset_full", 32'(bus.full), 32'd0);
      check("reset_overflow", 32'(bus.overflow), 32'd0);
      check("reset_byte_done", 32'(bus.byte_done), 32'd0);

      append(8'h41);
      append(8'h42);
      run_send(1'b0, 8'h00, 1'b0, 1'b0);

      run_send(1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < DEPTH + 1; i++) append(8'($urandom));
      run_send(1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) append(8'($urandom));
      run_send(1'b0, 8'h00, 1'b0, 1'b1);

      append(8'h7E);
      append(8'h31);
      run_send(1'b1, 8'h7E, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) append(8'($urandom));
      run_send(1'b0, 8'h00, 1'b1, 1'b0);

      append(8'h10);
      append(8'h20);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      line_q.delete();
      check("clear_count", 32'(bus.count), 32'd0);

      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(0, 8);
         for (int i = 0; i < len; i++) begin
            ch = ($urandom_range(0, 3) == 0) ? NL : 8'($urandom);
            append(ch);
         end
         run_send(1'($urandom), 8'($urandom), 1'b0, 1'($urandom));
      end

      for (int i = 0; i < 3; i++) append(8'($urandom));
      bus.send = 1'b1;
      @(negedge clk);
      bus.send = 1'b0;
      repeat (BYTE_T + 4 * CPB + 4 - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      line_q.delete();
      check("midreset_tx", 32'(bus.tx), 32'd1);
      check("midreset_busy", 32'(bus.busy), 32'd0);
      check("midreset_count", 32'(bus.count), 32'd0);
      tx_low  = 0;
      busy_hi = 0;
      repeat (400) begin
         @(negedge clk);
         if (!bus.tx) tx_low++;
         if (bus.busy) busy_hi++;
      end
      check("midreset_tx_quiet", 32'(tx_low), 32'd0);
      check("midreset_busy_quiet", 32'(busy_hi), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
